fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side adapter that drains a `fifo_v3`-style FIFO (`empty`/`pop`/`data` with show-ahead data) and presents its entries as a valid/ready stream toward the crossbar channel logic. A 2-entry registered output stage breaks the combinational path from downstream `ready_i` to the FIFO pop. An optional beat counter marks every `BURST_LEN`-th accepted beat with `last_o`.

## Interface
- `BURST_LEN`, default 4: beats per burst for `last_o` generation; legal range 1..256.
- `dtype`, default `logic [31:0]`: entry type; must match the FIFO's `dtype`.
- `CNT_WIDTH`, default `(BURST_LEN > 1) ? $clog2(BURST_LEN) : 1`: beat counter width. Derived; do not override.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of the output stage and beat counter.
- `fifo_empty_i`  in  1  FIFO empty flag.
- `fifo_data_i`  in  dtype  FIFO head entry; valid whenever `!fifo_empty_i`.
- `fifo_pop_o`  out  1  pops the FIFO head this cycle.
- `valid_o`  out  1  stream valid.
- `ready_i`  in  1  stream ready.
- `data_o`  out  dtype  stream payload.
- `last_o`  out  1  final beat of the current burst.

## Operation
- Output stage holds `occ` entries (0, 1 or 2) in registers `head` and `skid`. States:
  - EMPTY: `occ=0`.
  - ONE: `occ=1`, entry in `head`.
  - FULL: `occ=2`, older entry in `head`, newer in `skid`.
- `fifo_pop_o = !fifo_empty_i && (occ != 2) && !flush_i`. This is combinational from registered state and `fifo_empty_i` only, never from `ready_i`.
- `fire = valid_o && ready_i`; `valid_o = (occ != 0)`; `data_o = head`.
- Transitions:
  - pop only: `occ+1`. The new entry goes to `head` if `occ` was 0, otherwise to `skid`.
  - fire only: `occ-1`. In FULL, `skid` moves to `head`.
  - pop and fire in ONE: `head <= fifo_data_i`; `occ` stays 1.
  - pop and fire in EMPTY or FULL: impossible, because `valid_o=0` in EMPTY and no pop occurs in FULL.
- Order is strict FIFO order. No entry is dropped or duplicated.
- Stream rules:
  - Once `valid_o` rises, it and `data_o` stay stable until `fire`.
  - `valid_o` never depends combinationally on `ready_i`.
- `flush_i`:
  - next cycle `occ=0` and the beat counter is 0.
  - `fifo_pop_o=0` in the flush cycle.
  - A `fire` in the flush cycle is still seen by downstream, but the entry is discarded from the counter's view.
- Reset: `occ=0`, `head`/`skid` = `'0`, counter = 0. Therefore `valid_o=0`, `data_o='0`, `last_o=0`, and `fifo_pop_o=!fifo_empty_i`.
- Reset asserted mid-burst: all buffered entries are lost; the counter restarts at 0.

## Timing
- Latency: an entry at the FIFO head in cycle t is popped in cycle t (if `occ<2`) and appears on `valid_o`/`data_o` in cycle t+1.
- Throughput: 1 beat/cycle sustained with `ready_i=1` (steady state ONE, pop and fire every cycle).
- After `ready_i` has been low, the stage absorbs one extra beat (FULL), then stops popping. When `ready_i` returns, full rate resumes with no bubble.
- `last_o` is combinational from registered counter and `valid_o`; it has no added latency.

## Configuration
- `FIFO_STREAM_READER_LAST_EN` defined:
  - A `CNT_WIDTH`-bit counter increments on each `fire` and wraps from `BURST_LEN-1` to 0.
  - `last_o = valid_o && (cnt == BURST_LEN-1)`.
  - With `BURST_LEN=1`, `last_o = valid_o`.
- Not defined: no counter is instantiated; `last_o` is tied to 0. All other behaviour is identical.

## Test plan
- Reset with the FIFO holding 3 entries (0xA, 0xB, 0xC) and `ready_i=1`:
  - `valid_o=0` during reset.
  - After release, `fifo_pop_o=1` in cycles 0..2.
  - `data_o` = 0xA, 0xB, 0xC on consecutive cycles 1..3, then `valid_o=0`.
- Backpressure, FIFO holding 0x1..0x5, `ready_i=0` for 5 cycles:
  - exactly 2 pops, then `fifo_pop_o=0` with the FIFO non-empty.
  - `data_o` stays 0x1.
  - On `ready_i=1`, the outputs are 0x1..0x5 in order with no gap.
- Flush while FULL (`occ=2`, holding 0x7, 0x8), FIFO empty:
  - next cycle `valid_o=0`.
  - A later push of 0x9 emerges as the next beat, with `last_o` counting from beat 0.
- With `FIFO_STREAM_READER_LAST_EN` and `BURST_LEN=4`, stream 8 beats with random `ready_i` stalls: `last_o=1` exactly on accepted beats 4 and 8.
- Same run without the macro: the identical data sequence is produced and `last_o` is never 1.
- Reset asserted mid-burst after 2 of 4 beats: outputs return to their reset values asynchronously, and the next burst asserts `last_o` on its 4th beat.

Source files
------------

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Drains a show-ahead FIFO (empty/pop/data) and presents its
//            entries as a valid/ready stream. A two-entry registered output
//            stage (head + skid) keeps downstream ready_i out of the pop
//            path. An optional beat counter flags every BURST_LEN-th
//            accepted beat with last_o.
// Options  : FIFO_STREAM_READER_LAST_EN - when defined, the beat counter
//            and last_o generation are built; otherwise last_o is tied low.
// Ports    : clk_i        in   clock, rising-edge
//            rst_ni       in   asynchronous active-low reset
//            flush_i      in   synchronous clear of output stage + counter
//            fifo_empty_i in   FIFO empty flag
//            fifo_data_i  in   FIFO head entry (valid when !fifo_empty_i)
//            fifo_pop_o   out  pop the FIFO head this cycle
//            valid_o      out  stream valid
//            ready_i      in   stream ready
//            data_o       out  stream payload
//            last_o       out  final beat of the current burst
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int unsigned BURST_LEN = 4,
  parameter type         dtype     = logic [31:0],
  parameter int unsigned CNT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic fifo_empty_i,
  input  dtype fifo_data_i,
  output logic fifo_pop_o,
  output logic valid_o,
  input  logic ready_i,
  output dtype data_o,
  output logic last_o
);

  // Occupancy of the output stage; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  dtype   head_q, head_d;
  dtype   skid_q, skid_d;

  logic   pop;
  logic   fire;

  // Pop depends only on registered occupancy, the FIFO flag and flush; ready_i
  // is deliberately absent so no combinational path runs back into the FIFO.
  assign pop        = !fifo_empty_i && (state_q != S_FULL) && !flush_i;
  assign fifo_pop_o = pop;

  assign valid_o = (state_q != S_EMPTY);
  assign data_o  = head_q;
  assign fire    = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Buffered entries are simply abandoned; payload registers keep their
      // stale contents, which are invisible while valid_o is low.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (pop) begin
            head_d  = fifo_data_i;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (pop && fire) begin
            // Steady-state streaming: replace the departing head in place.
            head_d = fifo_data_i;
          end else if (pop) begin
            skid_d  = fifo_data_i;
            state_d = S_FULL;
          end else if (fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // No pop can happen here, so only a departure changes anything.
          if (fire) begin
            head_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(BURST_LEN - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Counts accepted beats within the burst. A beat accepted during a flush
  // still reaches downstream but does not advance the burst position.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = valid_o && (cnt_q == CNT_MAX);
`else
  // Burst tracking disabled: the sizing parameters are kept for interface
  // compatibility and only folded into a sink here.
  logic [CNT_WIDTH-1:0] unused_cnt_max;
  assign unused_cnt_max = CNT_WIDTH'(BURST_LEN - 1);

  assign last_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader. A queue stands in for
//            the FIFO; a queue-level model of the output stage plus a beat
//            count predicts pop/valid/data/last every cycle. Directed
//            scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int BL = 4;

  logic        clk;
  logic        rst_ni;
  logic        flush_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_pop_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        last_o;

  fifo_stream_reader #(
    .BURST_LEN(BL)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_pop_o  (fifo_pop_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO contents and the model of entries held by the reader.
  logic [31:0] fifo_q[$];
  logic [31:0] st_q[$];
  int          beats;

  int          n_cmp = 0;
  int          n_err = 0;

  logic        obs_pop, obs_valid, obs_last;
  logic [31:0] obs_data;
  int          tcount;
  logic [31:0] tmask;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, compare against the model,
  // then advance the model at the rising edge.
  task automatic cycle(input logic rdy, input logic fl);
    logic e_valid, e_pop, e_last, e_fire;
    @(negedge clk);
    ready_i      = rdy;
    flush_i      = fl;
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    #1;
    obs_pop   = fifo_pop_o;
    obs_valid = valid_o;
    obs_data  = data_o;
    obs_last  = last_o;

    e_valid = (st_q.size() != 0);
    e_pop   = (fifo_q.size() != 0) && (st_q.size() < 2) && !fl;
`ifdef FIFO_STREAM_READER_LAST_EN
    e_last  = e_valid && ((beats % BL) == BL - 1);
`else
    e_last  = 1'b0;
`endif
    check("pop", {31'd0, obs_pop}, {31'd0, e_pop});
    check("valid", {31'd0, obs_valid}, {31'd0, e_valid});
    check("last", {31'd0, obs_last}, {31'd0, e_last});
    if (e_valid) check("data", obs_data, st_q[0]);
    else if (!rst_ni) check("rst_data", obs_data, 32'd0);

    e_fire = e_valid && rdy;
    if (e_fire) begin
      tcount++;
      if (obs_last && tcount < 32) tmask = tmask | (32'd1 << tcount);
    end

    @(posedge clk);
    if (!rst_ni) begin
      st_q.delete();
      beats = 0;
    end else if (fl) begin
      st_q.delete();
      beats = 0;
    end else begin
      if (e_fire) begin
        void'(st_q.pop_front());
        beats++;
      end
      if (e_pop) st_q.push_back(fifo_q.pop_front());
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (st_q.size() != 0 || fifo_q.size() != 0); i++) cycle(1'b1, 1'b0);
    if (st_q.size() != 0 || fifo_q.size() != 0) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int npop;
    logic [31:0] exp_mask;

    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    ready_i      = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    beats        = 0;
    tcount       = 0;
    tmask        = '0;

    // Reset with A,B,C waiting, ready high.
    fifo_q.push_back(32'hA);
    fifo_q.push_back(32'hB);
    fifo_q.push_back(32'hC);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0);
      check("t1_rst_valid", {31'd0, obs_valid}, 32'd0);
    end
    #1 rst_ni = 1'b1;
    cycle(1'b1, 1'b0);
    check("t1_pop0", {31'd0, obs_pop}, 32'd1);
    check("t1_valid0", {31'd0, obs_valid}, 32'd0);
    cycle(1'b1, 1'b0);
    check("t1_pop1", {31'd0, obs_pop}, 32'd1);
    check("t1_data1", obs_data, 32'hA);
    cycle(1'b1, 1'b0);
    check("t1_pop2", {31'd0, obs_pop}, 32'd1);
    check("t1_data2", obs_data, 32'hB);
    cycle(1'b1, 1'b0);
    check("t1_data3", obs_data, 32'hC);
    cycle(1'b1, 1'b0);
    check("t1_valid4", {31'd0, obs_valid}, 32'd0);

    // Flush while FULL; burst position was 3, so without flush 0x9 would be last.
    fifo_q.push_back(32'h7);
    fifo_q.push_back(32'h8);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("t3_full_data", obs_data, 32'h7);
    check("t3_full_nopop", {31'd0, obs_pop}, 32'd0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("t3_flushed_valid", {31'd0, obs_valid}, 32'd0);
    fifo_q.push_back(32'h9);
    cycle(1'b1, 1'b0);
    check("t3_pop9", {31'd0, obs_pop}, 32'd1);
    cycle(1'b1, 1'b0);
    check("t3_data9", obs_data, 32'h9);
    check("t3_last9", {31'd0, obs_last}, 32'd0);
    drain();

    // Backpressure with 1..5 queued.
    for (int v = 1; v <= 5; v++) fifo_q.push_back(32'(v));
    npop = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      npop += int'(obs_pop);
      if (i >= 1) check("t2_hold_data", obs_data, 32'h1);
    end
    check("t2_pops", 32'(npop), 32'd2);
    check("t2_stalled_pop", {31'd0, obs_pop}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      check("t2_nogap_valid", {31'd0, obs_valid}, 32'd1);
      check("t2_seq", obs_data, 32'(i + 1));
    end
    drain();

    // Eight beats with random stalls, burst position restarted by a flush.
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    tcount = 0;
    tmask  = '0;
    for (int i = 0; i < 300 && tcount < 8; i++) cycle(1'($urandom_range(0, 1)), 1'b0);
    check("t4_beats", 32'(tcount), 32'd8);
`ifdef FIFO_STREAM_READER_LAST_EN
    exp_mask = 32'h110;
`else
    exp_mask = 32'h0;
`endif
    check("t4_last_mask", tmask, exp_mask);
    drain();

    // Asynchronous reset after two beats of a burst.
    cycle(1'b0, 1'b1);
    for (int v = 0; v < 4; v++) fifo_q.push_back(32'h60 + 32'(v));
    tcount = 0;
    for (int i = 0; i < 20 && tcount < 2; i++) cycle(1'b1, 1'b0);
    check("t6_pre_beats", 32'(tcount), 32'd2);
    #3 rst_ni = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, valid_o}, 32'd0);
    check("t6_async_data", data_o, 32'd0);
    check("t6_async_last", {31'd0, last_o}, 32'd0);
    st_q.delete();
    fifo_q.delete();
    beats = 0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    #1 rst_ni = 1'b1;
    for (int v = 0; v < 4; v++) fifo_q.push_back(32'h70 + 32'(v));
    tcount = 0;
    tmask  = '0;
    for (int i = 0; i < 20 && tcount < 4; i++) cycle(1'b1, 1'b0);
    check("t6_post_beats", 32'(tcount), 32'd4);
`ifdef FIFO_STREAM_READER_LAST_EN
    exp_mask = 32'h10;
`else
    exp_mask = 32'h0;
`endif
    check("t6_last_mask", tmask, exp_mask);

    // Random traffic with occasional flushes, checked cycle by cycle.
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 16 && $urandom_range(0, 2) != 0) fifo_q.push_back($urandom);
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
